i2s_adc_receiver: RTL and testbench
===================================

Name: i2s_adc_receiver

Overview:
Front-end capture stage between the WM8731 codec ADC pins and the audio sample consumer in the voice-game system. The codec is I2S master and drives BCLK, ADCLRCK and ADCDAT. This block oversamples those three pins in the clk_clk domain and deserialises stereo PCM frames. It delivers left/right sample pairs over a valid/ready handshake and keeps a peak-hold amplitude level for the game logic.

Parameters:
DATA_WIDTH, 16, bits per channel word captured (MSB first)
I2S_DELAY, 1, BCLK rising edges skipped after an LRCK transition before the MSB (1 = I2S mode, 0 = left-justified mode)
DECAY_PERIOD, 65536, clk_clk cycles between level decay steps
DECAY_SHIFT, 4, level decays by level>>DECAY_SHIFT per step

Ports:
clk_clk  in  1  system clock (50 MHz); sole clock
reset_reset_n  in  1  asynchronous active-low reset
audio_interface_ADCDAT  in  1  codec serial ADC data (asynchronous)
audio_interface_ADCLRCK  in  1  codec LR clock (asynchronous); low = left, high = right
audio_interface_BCLK  in  1  codec bit clock (asynchronous, at most clk_clk/8)
sample_left  out  DATA_WIDTH  signed left sample of the held pair
sample_right  out  DATA_WIDTH  signed right sample of the held pair
sample_valid  out  1  pair held and not yet consumed
sample_ready  in  1  consumer accepts the pair when high together with sample_valid
level  out  DATA_WIDTH  peak-hold magnitude, unsigned
overflow  out  1  sticky; a completed pair was dropped
frame_err  out  1  sticky; LRCK toggled before a word completed
clear_flags  in  1  synchronous clear of overflow and frame_err

Behaviour:
- Reset (async assert, sync release): all outputs 0. FSM goes to IDLE. Synchroniser flops go to 0.
- Input sampling: each pin passes through a 2-flop synchroniser, followed by one delay flop for edge detection.
- bclk_rise = sync_bclk & ~bclk_d. lrck_edge = sync_lrck ^ lrck_d. Data is sampled from sync_adcdat on the bclk_rise cycle.
- Pin-to-decision latency is 3 clk_clk cycles.
- FSM:
  - IDLE: wait for lrck_edge, then latch channel = sync_lrck and go to SKIP, or to SHIFT if I2S_DELAY=0.
  - SKIP: consume I2S_DELAY bclk_rise events, then go to SHIFT.
  - SHIFT: shift one bit in per bclk_rise, MSB first. After DATA_WIDTH bits, store the word in the left or right holding register and go to WAIT.
  - WAIT: ignore bits until the next lrck_edge, then latch channel and go to SKIP.
- An lrck_edge takes priority over a bclk_rise in the same cycle. The edge is processed first, and that bit does not count as a skip or data bit.
- An lrck_edge while in SKIP or SHIFT: set frame_err, discard the partial word, and restart at SKIP for the new channel.
- Pair emission: when a right word completes, the pair {last completed left, this right} is offered.
  - If sample_valid=0, or sample_valid=1 with sample_ready=1 in the same cycle: load the outputs and set sample_valid=1 on the next edge.
  - If sample_valid=1 with sample_ready=0: drop the new pair, keep the old one, and set overflow.
- Handshake: sample_valid clears on the cycle after sample_valid & sample_ready, unless a new pair loads in that same cycle. Held outputs stay stable while valid and not ready.
- Level:
  - The magnitude of each completed word is its two's-complement absolute value. The most negative value saturates to 2^(DATA_WIDTH-1)-1.
  - If magnitude > level, level takes the magnitude on the next cycle.
  - A free-running counter fires every DECAY_PERIOD cycles; on that cycle level <= level - (level>>DECAY_SHIFT).
  - If a load and a decay fall in the same cycle, the load wins.
- clear_flags clears both sticky flags. A same-cycle set wins over clear.
- Reset mid-word: the partial word and both holding registers are discarded. Capture resumes at the next lrck_edge.

Decomposition:
- Package i2s_rx_pkg holds:
  - the FSM state enum (IDLE, SKIP, SHIFT, WAIT);
  - the channel constants LEFT=0 and RIGHT=1;
  - a function abs_sat(word) returning the saturated magnitude.
- Sub-module i2s_pin_sync provides the 3-bit 2-flop synchroniser plus delay flop, and outputs bclk_rise, lrck_edge and data bit.
- Level tracker and handshake stay in the top level.

Test Plan:
1. Standard I2S, BCLK = clk/16, 32 BCLK per channel; left 0x1234, right 0xABCD; sample_ready held 1 -> sample_left=0x1234, sample_right=0xABCD, sample_valid high for exactly 1 cycle; level=0x5433.
2. Three frames sent with sample_ready held 0 -> first pair held unchanged, overflow=1 after the second right word. Then pulse clear_flags -> overflow=0.
3. LRCK toggles after 8 data bits of the left word -> frame_err=1, no pair emitted for that frame. The following clean frame (0x0001/0x0002) is delivered correctly.
4. Left word 0x8000 -> level=0x7FFF. Then silence (0x0000) with DECAY_PERIOD=16 -> level falls to 0x7800 after the first decay step and decreases monotonically after that.
5. I2S_DELAY=0 (left-justified) with left 0xFFFF, right 0x0000 -> sample_left=0xFFFF, sample_right=0x0000.
6. reset_reset_n asserted mid-SHIFT -> all outputs 0 immediately (asynchronous). After release, the first complete frame is delivered and no stale bits appear in sample_left.

Source files
------------

// File: rtl/i2s_rx_pkg.sv
// Shared types and helpers for the I2S ADC receiver.
//   rx_state_e : capture FSM states
//   LEFT/RIGHT : channel encoding, equal to the LRCK level of the slot
//   abs_sat    : saturated two's-complement magnitude of a word up to MAX_W bits
package i2s_rx_pkg;

  localparam int unsigned MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    WAIT  = 2'd3
  } rx_state_e;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  // Magnitude of the low `width` bits read as signed; the most negative value
  // saturates to the largest positive one so the result fits in width-1 bits.
  function automatic logic [MAX_W-1:0] abs_sat(input logic [MAX_W-1:0] word,
                                                input int unsigned      width);
    logic [MAX_W-1:0] msb;
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] mag;
    msb  = MAX_W'(1) << (width - 1);
    mask = (msb << 1) - MAX_W'(1);
    if ((word & msb) == '0) begin
      mag = word & mask;
    end else begin
      mag = (~word + MAX_W'(1)) & mask;
      if (mag == msb) mag = msb - MAX_W'(1);
    end
    return mag;
  endfunction

endpackage

// File: rtl/i2s_pin_sync.sv
// Brings the three asynchronous codec pins into clk_clk and detects edges.
//   bclk_pin/lrck_pin/adcdat_pin : raw codec pins
//   bclk_rise_c : one-cycle pulse on a synchronised BCLK rising edge
//   lrck_edge_c : one-cycle pulse on either synchronised LRCK edge
//   lrck_sync   : synchronised LRCK level (channel of the slot just started)
//   data_sync   : synchronised ADCDAT, valid to sample on bclk_rise_c
module i2s_pin_sync (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic bclk_pin,
  input  logic lrck_pin,
  input  logic adcdat_pin,
  output logic bclk_rise_c,
  output logic lrck_edge_c,
  output logic lrck_sync,
  output logic data_sync
);

  // Bit order in the pipelines: {bclk, lrck, adcdat}
  logic [2:0] meta_q, meta_d;
  logic [2:0] sync_q, sync_d;
  logic [1:0] dly_q, dly_d;   // {bclk, lrck} one cycle behind sync_q

  // Two synchroniser stages plus one delay stage for edge detection
  always_comb begin
    meta_d = {bclk_pin, lrck_pin, adcdat_pin};
    sync_d = meta_q;
    dly_d  = sync_q[2:1];
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
      dly_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign bclk_rise_c = sync_q[2] & ~dly_q[1];
  assign lrck_edge_c = sync_q[1] ^ dly_q[0];
  assign lrck_sync   = sync_q[1];
  assign data_sync   = sync_q[0];

endmodule

// File: rtl/i2s_adc_receiver.sv
// Deserialises stereo I2S (or left-justified) ADC frames from a WM8731 master,
// offers left/right pairs on a valid/ready handshake and tracks a decaying
// peak level.
//   clk_clk, reset_reset_n        : clock, async active-low reset
//   audio_interface_*             : asynchronous codec pins
//   sample_left/right/valid/ready : pair handshake (outputs held while valid)
//   level                         : peak-hold magnitude
//   overflow, frame_err           : sticky error flags, cleared by clear_flags
module i2s_adc_receiver
  import i2s_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned I2S_DELAY    = 1,
  parameter int unsigned DECAY_PERIOD = 65536,
  parameter int unsigned DECAY_SHIFT  = 4
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  audio_interface_ADCDAT,
  input  logic                  audio_interface_ADCLRCK,
  input  logic                  audio_interface_BCLK,
  output logic [DATA_WIDTH-1:0] sample_left,
  output logic [DATA_WIDTH-1:0] sample_right,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic [DATA_WIDTH-1:0] level,
  output logic                  overflow,
  output logic                  frame_err,
  input  logic                  clear_flags
);

  localparam int unsigned CNT_MAX = (I2S_DELAY > DATA_WIDTH) ? I2S_DELAY : DATA_WIDTH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned DCNT_W  = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam rx_state_e   START_ST = (I2S_DELAY == 0) ? SHIFT : SKIP;

  logic bclk_rise_c, lrck_edge_c, lrck_sync, data_sync;

  i2s_pin_sync u_pin_sync (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .bclk_pin      (audio_interface_BCLK),
    .lrck_pin      (audio_interface_ADCLRCK),
    .adcdat_pin    (audio_interface_ADCDAT),
    .bclk_rise_c   (bclk_rise_c),
    .lrck_edge_c   (lrck_edge_c),
    .lrck_sync     (lrck_sync),
    .data_sync     (data_sync)
  );

  rx_state_e             state_q, state_d;
  logic                  chan_q, chan_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                  left_ok_q, left_ok_d;
  logic [DATA_WIDTH-1:0] sample_left_q, sample_left_d;
  logic [DATA_WIDTH-1:0] sample_right_q, sample_right_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  frame_err_q, frame_err_d;
  logic [DCNT_W-1:0]     decay_cnt_q, decay_cnt_d;

  logic                  word_done;
  logic [DATA_WIDTH-1:0] word_c;
  logic [DATA_WIDTH-1:0] mag_c;
  logic                  decay_fire;

  assign word_c     = {shreg_q[DATA_WIDTH-2:0], data_sync};
  assign mag_c      = DATA_WIDTH'(abs_sat(MAX_W'(word_c), DATA_WIDTH));
  assign decay_fire = (decay_cnt_q == DCNT_W'(DECAY_PERIOD - 1));

  // Capture FSM, pair handshake, sticky flags and level tracker
  always_comb begin
    state_d        = state_q;
    chan_d         = chan_q;
    cnt_d          = cnt_q;
    shreg_d        = shreg_q;
    left_hold_d    = left_hold_q;
    left_ok_d      = left_ok_q;
    sample_left_d  = sample_left_q;
    sample_right_d = sample_right_q;
    valid_d        = valid_q;
    level_d        = level_q;
    overflow_d     = overflow_q;
    frame_err_d    = frame_err_q;
    decay_cnt_d    = decay_fire ? '0 : decay_cnt_q + DCNT_W'(1);
    word_done      = 1'b0;

    if (clear_flags) begin
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
    end

    // An LRCK edge starts a new slot and swallows any BCLK rise of the same cycle
    if (lrck_edge_c) begin
      if (state_q == SKIP || state_q == SHIFT) frame_err_d = 1'b1;
      chan_d  = lrck_sync;
      cnt_d   = '0;
      shreg_d = '0;
      state_d = START_ST;
    end else if (bclk_rise_c) begin
      case (state_q)
        SKIP: begin
          if (cnt_q == CNT_W'(I2S_DELAY - 1)) begin
            cnt_d   = '0;
            state_d = SHIFT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SHIFT: begin
          shreg_d = word_c;
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            word_done = 1'b1;
            cnt_d     = '0;
            state_d   = WAIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end

    if (valid_q && sample_ready) valid_d = 1'b0;

    // A pair needs a left word completed since the last offered pair
    if (word_done && chan_q == LEFT) begin
      left_hold_d = word_c;
      left_ok_d   = 1'b1;
    end
    if (word_done && chan_q == RIGHT && left_ok_q) begin
      left_ok_d = 1'b0;
      if (!valid_q || sample_ready) begin
        sample_left_d  = left_hold_q;
        sample_right_d = word_c;
        valid_d        = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    // Decay first so a same-cycle peak load overrides it
    if (decay_fire) level_d = level_q - (level_q >> DECAY_SHIFT);
    if (word_done && mag_c > level_q) level_d = mag_c;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q        <= IDLE;
      chan_q         <= LEFT;
      cnt_q          <= '0;
      shreg_q        <= '0;
      left_hold_q    <= '0;
      left_ok_q      <= 1'b0;
      sample_left_q  <= '0;
      sample_right_q <= '0;
      valid_q        <= 1'b0;
      level_q        <= '0;
      overflow_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      decay_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      chan_q         <= chan_d;
      cnt_q          <= cnt_d;
      shreg_q        <= shreg_d;
      left_hold_q    <= left_hold_d;
      left_ok_q      <= left_ok_d;
      sample_left_q  <= sample_left_d;
      sample_right_q <= sample_right_d;
      valid_q        <= valid_d;
      level_q        <= level_d;
      overflow_q     <= overflow_d;
      frame_err_q    <= frame_err_d;
      decay_cnt_q    <= decay_cnt_d;
    end
  end

  assign sample_left  = sample_left_q;
  assign sample_right = sample_right_q;
  assign sample_valid = valid_q;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench: a codec model drives I2S frames, a scoreboard queue holds
// the pairs expected on dut_a's handshake. dut_b shares dut_a's pins with a
// short decay period; dut_c receives left-justified frames.
module tb_i2s_adc_receiver;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic bclk, lrck, dat, lj_mode;
  logic a_bclk, a_lrck, a_dat, c_bclk, c_lrck, c_dat;
  logic ready_a, ready_c, clear_flags;

  logic [W-1:0] left_a, right_a, level_a;
  logic [W-1:0] left_b, right_b, level_b;
  logic [W-1:0] left_c, right_c, level_c;
  logic valid_a, ovf_a, ferr_a;
  logic valid_b, ovf_b, ferr_b;
  logic valid_c, ovf_c, ferr_c;

  int n_pass  = 0;
  int n_total = 0;
  int vcount  = 0;
  logic [W-1:0] exp_l[$];
  logic [W-1:0] exp_r[$];

  always #5 clk = ~clk;

  assign a_bclk = lj_mode ? 1'b0 : bclk;
  assign a_lrck = lj_mode ? 1'b0 : lrck;
  assign a_dat  = lj_mode ? 1'b0 : dat;
  assign c_bclk = lj_mode ? bclk : 1'b0;
  assign c_lrck = lj_mode ? lrck : 1'b0;
  assign c_dat  = lj_mode ? dat  : 1'b0;

  i2s_adc_receiver #(.DATA_WIDTH(W), .I2S_DELAY(1), .DECAY_PERIOD(65536), .DECAY_SHIFT(4)) dut_a (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .audio_interface_ADCDAT(a_dat), .audio_interface_ADCLRCK(a_lrck), .audio_interface_BCLK(a_bclk),
    .sample_left(left_a), .sample_right(right_a), .sample_valid(valid_a), .sample_ready(ready_a),
    .level(level_a), .overflow(ovf_a), .frame_err(ferr_a), .clear_flags(clear_flags));

  i2s_adc_receiver #(.DATA_WIDTH(W), .I2S_DELAY(1), .DECAY_PERIOD(16), .DECAY_SHIFT(4)) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .audio_interface_ADCDAT(a_dat), .audio_interface_ADCLRCK(a_lrck), .audio_interface_BCLK(a_bclk),
    .sample_left(left_b), .sample_right(right_b), .sample_valid(valid_b), .sample_ready(1'b1),
    .level(level_b), .overflow(ovf_b), .frame_err(ferr_b), .clear_flags(clear_flags));

  i2s_adc_receiver #(.DATA_WIDTH(W), .I2S_DELAY(0), .DECAY_PERIOD(65536), .DECAY_SHIFT(4)) dut_c (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .audio_interface_ADCDAT(c_dat), .audio_interface_ADCLRCK(c_lrck), .audio_interface_BCLK(c_bclk),
    .sample_left(left_c), .sample_right(right_c), .sample_valid(valid_c), .sample_ready(ready_c),
    .level(level_c), .overflow(ovf_c), .frame_err(ferr_c), .clear_flags(clear_flags));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One LRCK slot of len BCLK periods (16 clk each); data changes while BCLK is low
  task automatic send_slot(input logic ch, input logic [W-1:0] word, input int delay, input int len);
    for (int i = 0; i < len; i++) begin
      bclk = 1'b0;
      if (i == 0) lrck = ch;
      if (i >= delay && i < delay + int'(W)) dat = word[W-1-(i-delay)];
      else dat = 1'b0;
      tick(8);
      bclk = 1'b1;
      tick(8);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int delay);
    send_slot(1'b0, l, delay, 32);
    send_slot(1'b1, r, delay, 32);
  endtask

  // Scoreboard: every accepted pair on dut_a must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && valid_a) vcount++;
    if (rst_n && valid_a && ready_a) begin
      check("sb_pair_expected", 32'(exp_l.size() != 0), 32'd1);
      if (exp_l.size() != 0) begin
        check("sb_left", 32'(left_a), 32'(exp_l.pop_front()));
        check("sb_right", 32'(right_a), 32'(exp_r.pop_front()));
      end
    end
  end

  initial begin
    int       vmark;
    int       k;
    logic     mono;
    logic [W-1:0] prev;

    rst_n = 1'b0; bclk = 1'b0; lrck = 1'b0; dat = 1'b0; lj_mode = 1'b0;
    ready_a = 1'b1; ready_c = 1'b0; clear_flags = 1'b0;
    tick(4);
    check("rst_left", 32'(left_a), 32'h0);
    check("rst_right", 32'(right_a), 32'h0);
    check("rst_valid", 32'(valid_a), 32'h0);
    check("rst_level", 32'(level_a), 32'h0);
    check("rst_flags", 32'({ovf_a, ferr_a}), 32'h0);
    rst_n = 1'b1;
    tick(4);
    // Lone right slot so the first left slot begins with a real LRCK edge
    send_slot(1'b1, 16'h0000, 1, 32);

    // Basic I2S frame with ready held high
    vmark = vcount;
    exp_l.push_back(16'h1234); exp_r.push_back(16'hABCD);
    send_frame(16'h1234, 16'hABCD, 1);
    check("t1_valid_cycles", 32'(vcount - vmark), 32'd1);
    check("t1_level", 32'(level_a), 32'h5433);
    check("t1_drained", 32'(exp_l.size()), 32'd0);

    // Back-pressure: first pair held, later pairs dropped
    ready_a = 1'b0;
    exp_l.push_back(16'h1111); exp_r.push_back(16'h2222);
    send_frame(16'h1111, 16'h2222, 1);
    check("t2_valid_held", 32'(valid_a), 32'd1);
    check("t2_ovf_after_first", 32'(ovf_a), 32'd0);
    send_frame(16'h3333, 16'h4444, 1);
    check("t2_ovf_after_second", 32'(ovf_a), 32'd1);
    check("t2_left_stable", 32'(left_a), 32'h1111);
    send_frame(16'h5555, 16'h6666, 1);
    check("t2_right_stable", 32'(right_a), 32'h2222);
    clear_flags = 1'b1; tick(1); clear_flags = 1'b0;
    check("t2_ovf_cleared", 32'(ovf_a), 32'd0);
    ready_a = 1'b1;
    tick(3);
    check("t2_drained", 32'(exp_l.size()), 32'd0);
    check("t2_valid_dropped", 32'(valid_a), 32'd0);

    // Short left word: frame error and no pair for that frame
    send_slot(1'b0, 16'hFFFF, 1, 9);
    send_slot(1'b1, 16'h7777, 1, 32);
    check("t3_frame_err", 32'(ferr_a), 32'd1);
    check("t3_no_pair", 32'(valid_a), 32'd0);
    exp_l.push_back(16'h0001); exp_r.push_back(16'h0002);
    send_frame(16'h0001, 16'h0002, 1);
    check("t3_recovered", 32'(exp_l.size()), 32'd0);
    clear_flags = 1'b1; tick(1); clear_flags = 1'b0;
    check("t3_ferr_cleared", 32'(ferr_a), 32'd0);

    // Saturated peak then decay on the fast-decay instance
    exp_l.push_back(16'h8000); exp_r.push_back(16'h0000);
    fork
      send_frame(16'h8000, 16'h0000, 1);
      begin
        k = 0;
        while (level_b !== 16'h7FFF && k < 1500) begin tick(1); k++; end
        check("t4_peak_b", 32'(level_b), 32'h7FFF);
        k = 0;
        while (level_b === 16'h7FFF && k < 64) begin tick(1); k++; end
        check("t4_first_decay", 32'(level_b), 32'h7800);
        mono = 1'b1;
        prev = level_b;
        repeat (200) begin
          tick(1);
          if (level_b > prev) mono = 1'b0;
          prev = level_b;
        end
        check("t4_monotonic", 32'(mono), 32'd1);
        check("t4_decreased", 32'(level_b < 16'h7800), 32'd1);
      end
    join
    check("t4_peak_a", 32'(level_a), 32'h7FFF);
    check("t4_drained", 32'(exp_l.size()), 32'd0);

    // Asynchronous reset in the middle of a left word
    fork
      send_frame(16'hDEAD, 16'hBEEF, 1);
      begin
        tick(164);
        rst_n = 1'b0;
        #1;
        check("t6_rst_left", 32'(left_a), 32'h0);
        check("t6_rst_level", 32'(level_a), 32'h0);
        check("t6_rst_valid", 32'(valid_a), 32'h0);
        tick(3);
        rst_n = 1'b1;
      end
    join
    check("t6_no_partial_pair", 32'(valid_a), 32'd0);
    exp_l.push_back(16'h0F0F); exp_r.push_back(16'h7070);
    send_frame(16'h0F0F, 16'h7070, 1);
    check("t6_drained", 32'(exp_l.size()), 32'd0);
    check("t6_left", 32'(left_a), 32'h0F0F);
    check("t6_level", 32'(level_a), 32'h7070);

    // Left-justified instance
    bclk = 1'b0; lrck = 1'b0; dat = 1'b0;
    tick(32);
    lj_mode = 1'b1;
    tick(8);
    send_slot(1'b1, 16'h0000, 0, 32);
    send_frame(16'hFFFF, 16'h0000, 0);
    check("t5_valid", 32'(valid_c), 32'd1);
    check("t5_left", 32'(left_c), 32'hFFFF);
    check("t5_right", 32'(right_c), 32'h0000);
    check("t5_level", 32'(level_c), 32'h0001);

    check("end_drained", 32'(exp_l.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
